// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART
// transmit and receive paths.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int TICK_W = $clog2(OVERSAMPLE);

  localparam int NONE = 0;
  localparam int EVEN = 1;
  localparam int ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic bit stop_bits_ok(int n);
    return (n == 1) || (n == 2);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake between a byte source
// and the UART transmitter.
interface uart_tx_if;

  logic [7:0] Di;
  logic       valid;
  logic       ready;

  modport master (
    output Di,
    output valid,
    input  ready
  );

  modport slave (
    input  Di,
    input  valid,
    output ready
  );

endinterface

// File: rtl/uart_tx.sv
// uart_tx: byte-wide UART transmitter, 8 data bits LSB
// first, optional parity, 1 or 2 stop bits, x16 ticks.
module uart_tx
  import uart_pkg::*;
#(
  parameter int P_PARITY    = 0,
  parameter int P_STOP_BITS = 1
) (
  input  logic     CLK,
  input  logic     reset,
  input  logic     x16_BAUD,
  uart_tx_if.slave src,
  output logic     serial_out,
  output logic     busy,
  output logic     done
);

  if (!stop_bits_ok(P_STOP_BITS)) begin : g_bad_stop
    $error("uart_tx: P_STOP_BITS must be 1 or 2");
  end

  localparam logic [TICK_W-1:0] TICK_LAST =
    TICK_W'(OVERSAMPLE - 1);
  localparam logic ODD_INV  = (P_PARITY == ODD);
  localparam logic HAS_PAR  = (P_PARITY != NONE);
  localparam logic TWO_STOP = (P_STOP_BITS == 2);

  tx_state_t         state, state_n;
  logic [TICK_W-1:0] tick_cnt, tick_n;
  logic [2:0]        bit_idx, bit_n;
  logic [7:0]        shift_reg, shift_n;
  logic              par_bit, par_n;
  logic              stop_cnt, stop_n;
  logic              so_n, done_n;
  logic              bit_end;

  assign src.ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign bit_end   = x16_BAUD && (tick_cnt == TICK_LAST);

  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_idx;
    shift_n = shift_reg;
    par_n   = par_bit;
    stop_n  = stop_cnt;
    done_n  = 1'b0;
    so_n    = 1'b1;
    // a tick in the accept cycle is deliberately not counted
    if (state == IDLE) begin
      if (src.valid) begin
        shift_n = src.Di;
        par_n   = (^src.Di) ^ ODD_INV;
        tick_n  = '0;
        bit_n   = '0;
        stop_n  = 1'b0;
        state_n = START;
      end
    end else if (x16_BAUD) begin
      tick_n = tick_cnt + 1'b1;
      if (bit_end) begin
        unique case (state)
          START: state_n = DATA;
          DATA: begin
            shift_n = shift_reg >> 1;
            bit_n   = bit_idx + 1'b1;
            if (bit_idx == 3'd7)
              state_n = HAS_PAR ? PARITY : STOP;
          end
          PARITY: state_n = STOP;
          STOP: begin
            if (TWO_STOP && !stop_cnt) begin
              stop_n = 1'b1;
            end else begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end
          default: state_n = IDLE;
        endcase
      end
    end
    // line level is decoded from the next state so it is registered
    unique case (state_n)
      START:   so_n = 1'b0;
      DATA:    so_n = shift_n[0];
      PARITY:  so_n = par_n;
      default: so_n = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      par_bit    <= 1'b0;
      stop_cnt   <= 1'b0;
      serial_out <= 1'b1;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      tick_cnt   <= tick_n;
      bit_idx    <= bit_n;
      shift_reg  <= shift_n;
      par_bit    <= par_n;
      stop_cnt   <= stop_n;
      serial_out <= so_n;
      done       <= done_n;
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-wide UART transmitter, the transmit-direction counterpart of the existing UART receive path. Accepts one byte per valid/ready handshake and serializes it as start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits. Bit timing comes from the shared x16 oversampling tick produced by `pulse_generator`; each bit spans exactly 16 ticks. The transmitter sits between a byte source (FIFO or control logic) and the serial line, and can loop back into `UART_RX` for self-test.

## Interface
- `P_PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `P_STOP_BITS`, default 1: 1 or 2; any other value is illegal.
- `CLK` input, 1 bit: system clock, all logic is on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `x16_BAUD` input, 1 bit: one-cycle tick enable at 16x the baud rate.
- `Di` input, 8 bits: byte to send, sampled when `valid && ready`.
- `valid` input, 1 bit: source has a byte on `Di`.
- `ready` output, 1 bit: transmitter is IDLE and accepts a byte this cycle.
- `serial_out` output, 1 bit: TX line, idle high.
- `busy` output, 1 bit: a frame is in progress (the inverse of `ready`).
- `done` output, 1 bit: one-cycle pulse when the final stop bit completes.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- **IDLE:** `serial_out`=1, `ready`=1, `busy`=0.
  - On `valid`, latch `Di` into the shift register.
  - Clear `tick_cnt` (4 bits) and `bit_idx` (3 bits).
  - Go to START.
- **Bit period:** in every non-IDLE state, each `x16_BAUD` pulse increments `tick_cnt`. A pulse while `tick_cnt`==15 ends the current bit: `tick_cnt` wraps to 0 and the state advances.
- **START:** `serial_out`=0. Next state is DATA.
- **DATA:** `serial_out`=shift_reg[0].
  - At each bit end, shift right and increment `bit_idx`.
  - After the bit with `bit_idx`==7, go to PARITY if `P_PARITY`≠0, otherwise go to STOP.
- **PARITY:** `serial_out` = XOR of the latched byte for even parity, its inverse for odd parity. The parity value is computed at latch time and stored in a 1-bit register. Next state is STOP.
- **STOP:** `serial_out`=1 for `P_STOP_BITS`×16 ticks. A 1-bit stop counter is used when `P_STOP_BITS`=2. At the end, assert `done` and go to IDLE.
- **Outputs:** `serial_out` is registered, so there are no glitches.
- **Holding `valid`:** `Di` is ignored while `busy`. Holding `valid` high gives back-to-back frames, with the next byte accepted in the first IDLE cycle.
- **Tick on the accept cycle:** an `x16_BAUD` pulse in the cycle `valid` is accepted is not counted.

## Timing
- **Reset values:** `serial_out`=1, `ready`=1, `busy`=0, `done`=0, state IDLE, all counters 0. `reset` wins over every other input.
- **Start latency:** handshake in cycle N gives `serial_out`=0 and `busy`=1 from cycle N+1.
- **Frame length:** (1 + 8 + parity + `P_STOP_BITS`) × 16 ticks, measured from the first counted tick.
- **End of frame:** `done`=1 in the single cycle after the last stop-bit tick. `ready` is also 1 in that cycle, so a new handshake is possible the same cycle `done` is high.
- **Minimum idle gap:** with `valid` held high, the idle-high gap between frames is 1 clock cycle.
- **Reset mid-frame:** the next cycle shows `serial_out`=1 and IDLE. The partial frame is abandoned and `done` is not pulsed.
- **No ticks:** if `x16_BAUD` never pulses, the FSM holds its state indefinitely and `serial_out` stays at the current bit value.

## Structure
- **Shared package `uart_pkg`:**
  - state encoding;
  - parity mode constants NONE/EVEN/ODD;
  - the oversampling constant 16, also used by the receiver;
  - the stop-bit-count legality check.
- **Sub-modules:** none; the design is a single FSM with tick/bit counters and a shift register.
- **Tick source:** the tick generator stays external and shared with RX, using `pulse_generator`.

## Test plan
All scenarios drive `x16_BAUD` as a one-cycle pulse every 4 clocks.
- **8N1 pattern:** send 0xA5 → `serial_out` reads 0,1,0,1,0,0,1,0,1,1, each bit 64 clocks. `done` pulses 640 clocks after the first counted tick. `ready` is 0 throughout the frame.
- **Parity modes:**
  - `P_PARITY`=1, byte 0x07 → parity bit 1.
  - `P_PARITY`=2, byte 0x07 → parity bit 0.
  - Frame is 11 bits.
- **Two stop bits:** `P_STOP_BITS`=2, byte 0x00 → 9 low bits, then high for 32 ticks before `done`.
- **Back-to-back:** `valid` held high over 0x12 then 0x34 → two frames separated by exactly 1 idle clock. Exactly 2 `done` pulses. `Di` changes while `busy` are ignored.
- **Reset mid-frame:** assert `reset` during data bit 3 → `serial_out`=1 and `ready`=1 next cycle, no `done`. A following 0x5A transmits correctly.
- **Loopback:** `serial_out` into `UART_RX` sharing the same tick, 256 random bytes → every byte received with `valid`, `error` never asserted.
